// File: rtl/chg_txt_issuer.sv
// -----------------------------------------------------------------------------
// chg_txt_issuer
// Source end of the change-text interface. Host change records
// {row, col, real, img} are queued in a small FIFO. Each record is launched to
// the integrator with a one-cycle chg_start pulse. The issuer then waits for
// integ_done and returns the 48-bit Y result tagged with the record's row/col.
// An integrator that never answers is aborted after TIMEOUT cycles.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   wr_en, wr_*           host push strobe and record fields
//   full, empty, count    FIFO occupancy status
//   chg_*                 issued record (held until the next launch)
//   chg_start             one-cycle launch pulse
//   integ_done/yval       integrator completion pulse and result
//   res_*                 captured result; res_valid pulses once per result
//   busy                  high while waiting on the integrator
//   err_timeout           sticky, integrator did not answer in time
//   err_overflow          sticky, a host write was dropped while full
//   clr_err               clears both sticky flags
// -----------------------------------------------------------------------------
module chg_txt_issuer #(
  parameter int DEPTH   = 8,
  parameter int PTR_W   = 3,
  parameter int TIMEOUT = 64,
  parameter int TMR_W   = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [15:0]      wr_row,
  input  logic [15:0]      wr_col,
  input  logic [23:0]      wr_real,
  input  logic [23:0]      wr_img,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic [15:0]      chg_row,
  output logic [15:0]      chg_col,
  output logic [23:0]      chg_real,
  output logic [23:0]      chg_img,
  output logic             chg_start,
  input  logic             integ_done,
  input  logic [47:0]      integ_yval,
  output logic [47:0]      res_yval,
  output logic [15:0]      res_row,
  output logic [15:0]      res_col,
  output logic             res_valid,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_overflow,
  input  logic             clr_err
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  localparam logic [PTR_W:0]   C_FULL     = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   C_ONE_CNT  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] C_ONE_PTR  = PTR_W'(1);
  localparam logic [TMR_W-1:0] C_ONE_TMR  = TMR_W'(1);
  localparam logic [TMR_W-1:0] C_TMO_LAST = TMR_W'(TIMEOUT - 1);

  logic [79:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_full;
  logic             r_empty;
  state_t           r_state;
  state_t           w_next;
  logic [TMR_W-1:0] r_timer;
  logic [15:0]      r_chg_row;
  logic [15:0]      r_chg_col;
  logic [23:0]      r_chg_real;
  logic [23:0]      r_chg_img;
  logic             r_chg_start;
  logic [47:0]      r_res_yval;
  logic [15:0]      r_res_row;
  logic [15:0]      r_res_col;
  logic             r_res_valid;
  logic             r_busy;
  logic             r_err_timeout;
  logic             r_err_overflow;

  logic             w_push;
  logic             w_ovf_evt;
  logic             w_launch;
  logic             w_accept;
  logic             w_tmo_evt;
  logic [PTR_W:0]   w_count_nxt;
  logic [79:0]      w_head;

  // Full is taken from the registered count, so a write on a popping edge
  // is still dropped when the FIFO was full before that edge.
  assign w_push    = wr_en & ~r_full;
  assign w_ovf_evt = wr_en & r_full;
  assign w_head    = r_mem[r_rd_ptr];

  // Next-state and launch/accept/timeout decode.
  always_comb begin
    w_next    = r_state;
    w_launch  = 1'b0;
    w_accept  = 1'b0;
    w_tmo_evt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != {(PTR_W+1){1'b0}}) begin
          w_launch = 1'b1;
          w_next   = ST_WAIT;
        end else begin
          w_next   = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A done arriving on the timeout edge still wins.
        if (integ_done) begin
          w_accept = 1'b1;
          w_next   = ST_IDLE;
        end else if (r_timer == C_TMO_LAST) begin
          w_tmo_evt = 1'b1;
          w_next    = ST_IDLE;
        end else begin
          w_next    = ST_WAIT;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Occupancy after this edge's push and pop.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_launch})
      2'b10:   w_count_nxt = r_count + C_ONE_CNT;
      2'b01:   w_count_nxt = r_count - C_ONE_CNT;
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {wr_row, wr_col, wr_real, wr_img};
    end
  end

  // FIFO pointers, occupancy and status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {(PTR_W+1){1'b0}};
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push)   r_wr_ptr <= r_wr_ptr + C_ONE_PTR;
      if (w_launch) r_rd_ptr <= r_rd_ptr + C_ONE_PTR;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == C_FULL);
      r_empty <= (w_count_nxt == {(PTR_W+1){1'b0}});
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Launch registers, wait timer and result capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_timer     <= {TMR_W{1'b0}};
      r_chg_row   <= 16'h0000;
      r_chg_col   <= 16'h0000;
      r_chg_real  <= 24'h000000;
      r_chg_img   <= 24'h000000;
      r_chg_start <= 1'b0;
      r_res_yval  <= 48'h0;
      r_res_row   <= 16'h0000;
      r_res_col   <= 16'h0000;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_chg_start <= w_launch;
      r_res_valid <= w_accept;
      r_busy      <= (w_next == ST_WAIT);
      if (w_launch) begin
        {r_chg_row, r_chg_col, r_chg_real, r_chg_img} <= w_head;
        r_timer <= {TMR_W{1'b0}};
      end else if (r_state == ST_WAIT) begin
        r_timer <= r_timer + C_ONE_TMR;
      end
      if (w_accept) begin
        r_res_yval <= integ_yval;
        r_res_row  <= r_chg_row;
        r_res_col  <= r_chg_col;
      end
    end
  end

  // Sticky error flags; a same-edge event beats clr_err.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err_timeout  <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_err_timeout  <= w_tmo_evt | (r_err_timeout  & ~clr_err);
      r_err_overflow <= w_ovf_evt | (r_err_overflow & ~clr_err);
    end
  end

  assign full         = r_full;
  assign empty        = r_empty;
  assign count        = r_count;
  assign chg_row      = r_chg_row;
  assign chg_col      = r_chg_col;
  assign chg_real     = r_chg_real;
  assign chg_img      = r_chg_img;
  assign chg_start    = r_chg_start;
  assign res_yval     = r_res_yval;
  assign res_row      = r_res_row;
  assign res_col      = r_res_col;
  assign res_valid    = r_res_valid;
  assign busy         = r_busy;
  assign err_timeout  = r_err_timeout;
  assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_chg_txt_issuer.sv
// Bench for chg_txt_issuer: a queue-based reference model predicts each
// edge's outcome; a monitor compares DUT outputs on the falling edge and pops
// expected launches/results from scoreboard queues when the DUT presents them.
module tb_chg_txt_issuer;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_row = 16'h0, wr_col = 16'h0;
  logic [23:0] wr_real = 24'h0, wr_img = 24'h0;
  logic        integ_done = 1'b0;
  logic [47:0] integ_yval = 48'h0;
  logic        clr_err = 1'b0;
  logic        full, empty, chg_start, res_valid, busy, err_timeout, err_overflow;
  logic [3:0]  count;
  logic [15:0] chg_row, chg_col, res_row, res_col;
  logic [23:0] chg_real, chg_img;
  logic [47:0] res_yval;

  chg_txt_issuer #(.DEPTH(8), .PTR_W(3), .TIMEOUT(64), .TMR_W(7)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_real(wr_real), .wr_img(wr_img), .full(full), .empty(empty), .count(count),
    .chg_row(chg_row), .chg_col(chg_col), .chg_real(chg_real), .chg_img(chg_img),
    .chg_start(chg_start), .integ_done(integ_done), .integ_yval(integ_yval),
    .res_yval(res_yval), .res_row(res_row), .res_col(res_col), .res_valid(res_valid),
    .busy(busy), .err_timeout(err_timeout), .err_overflow(err_overflow), .clr_err(clr_err)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [79:0] m_fifo[$];
  logic [79:0] exp_issue[$];
  logic [79:0] exp_res[$];
  bit          m_busy = 1'b0, m_start = 1'b0, m_resv = 1'b0, m_ovf = 1'b0, m_tmo = 1'b0;
  int          m_timer = 0;
  logic [79:0] m_chg = 80'h0;
  logic [47:0] m_ryval = 48'h0;
  logic [15:0] m_rrow = 16'h0, m_rcol = 16'h0;
  bit          mf_full, mf_ovf, mf_tmo;
  logic [79:0] mf_rec;

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_fifo.delete(); exp_issue.delete(); exp_res.delete();
      m_busy = 1'b0; m_start = 1'b0; m_resv = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0;
      m_timer = 0; m_chg = 80'h0; m_ryval = 48'h0; m_rrow = 16'h0; m_rcol = 16'h0;
    end else begin
      mf_full = (m_fifo.size() == DEPTH);
      mf_ovf = 1'b0; mf_tmo = 1'b0; m_start = 1'b0; m_resv = 1'b0;
      if (!m_busy) begin
        if (m_fifo.size() > 0) begin
          mf_rec = m_fifo.pop_front();
          m_chg = mf_rec; m_start = 1'b1; m_busy = 1'b1; m_timer = 0;
          exp_issue.push_back(mf_rec);
        end
      end else if (integ_done) begin
        m_resv = 1'b1; m_ryval = integ_yval;
        m_rrow = m_chg[79:64]; m_rcol = m_chg[63:48]; m_busy = 1'b0;
        exp_res.push_back({m_rrow, m_rcol, m_ryval});
      end else if (m_timer == TIMEOUT - 1) begin
        mf_tmo = 1'b1; m_busy = 1'b0;
      end else begin
        m_timer++;
      end
      if (wr_en) begin
        if (mf_full) mf_ovf = 1'b1;
        else m_fifo.push_back({wr_row, wr_col, wr_real, wr_img});
      end
      m_ovf = mf_ovf | (m_ovf & !clr_err);
      m_tmo = mf_tmo | (m_tmo & !clr_err);
    end
  end

  // ---------------- monitor ----------------
  logic [79:0] mon_e;
  initial forever begin
    @(negedge clock);
    chk("count", 80'(count), 80'(m_fifo.size()));
    chk("full", 80'(full), 80'(m_fifo.size() == DEPTH));
    chk("empty", 80'(empty), 80'(m_fifo.size() == 0));
    chk("busy", 80'(busy), 80'(m_busy));
    chk("err_timeout", 80'(err_timeout), 80'(m_tmo));
    chk("err_overflow", 80'(err_overflow), 80'(m_ovf));
    chk("chg_start", 80'(chg_start), 80'(m_start));
    chk("res_valid", 80'(res_valid), 80'(m_resv));
    chk("chg_fields", {chg_row, chg_col, chg_real, chg_img}, m_chg);
    chk("res_fields", {res_row, res_col, res_yval}, {m_rrow, m_rcol, m_ryval});
    if (chg_start === 1'b1) begin
      if (exp_issue.size() == 0) chk("issue_unexpected", 80'h1, 80'h0);
      else begin
        mon_e = exp_issue.pop_front();
        chk("issue_record", {chg_row, chg_col, chg_real, chg_img}, mon_e);
      end
    end
    if (res_valid === 1'b1) begin
      if (exp_res.size() == 0) chk("result_unexpected", 80'h1, 80'h0);
      else begin
        mon_e = exp_res.pop_front();
        chk("result_record", {res_row, res_col, res_yval}, mon_e);
      end
    end
  end

  // ---------------- integrator model ----------------
  bit          stall = 1'b0, rand_delay = 1'b0, use_fixed = 1'b0, idle_kick = 1'b0;
  int          fix_delay = 0;
  logic [47:0] fixed_y = 48'h0;
  bit          pend = 1'b0;
  int          cnt = 0;

  initial forever begin
    @(posedge clock); #3;
    integ_done = 1'b0;
    if (reset) pend = 1'b0;
    else begin
      if (chg_start) begin
        pend = 1'b1;
        cnt = rand_delay ? int'($urandom_range(0, 4)) : fix_delay;
      end
      if (idle_kick) begin
        integ_done = 1'b1; integ_yval = {16'($urandom), $urandom}; idle_kick = 1'b0;
      end else if (pend && !stall) begin
        if (cnt == 0) begin
          integ_done = 1'b1; pend = 1'b0;
          integ_yval = use_fixed ? fixed_y : {16'($urandom), $urandom};
        end else cnt--;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic push(input logic [15:0] r, input logic [15:0] c,
                      input logic [23:0] re, input logic [23:0] im);
    wr_en = 1'b1; wr_row = r; wr_col = c; wr_real = re; wr_img = im;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    tick(2);
    // 1: single record, done 5 cycles after launch with a known value
    use_fixed = 1'b1; fixed_y = 48'h00001234ABCD; fix_delay = 5;
    push(16'h0000, 16'h0010, 24'h4ebd90, 24'h5c2e27);
    tick(12);
    chk("t1_res_yval", 80'(res_yval), 80'h00001234ABCD);
    chk("t1_res_col", 80'(res_col), 80'h0010);
    use_fixed = 1'b0;
    // 2: fill while the integrator stalls, overflow one write, then drain
    stall = 1'b1; fix_delay = 3;
    for (int i = 1; i <= 9; i++) push(16'(i * 3), 16'(i), 24'($urandom), 24'($urandom));
    push(16'h00AA, 16'h00AA, 24'h0, 24'h0);
    chk("t2_full", 80'(full), 80'h1);
    chk("t2_overflow", 80'(err_overflow), 80'h1);
    tick(15);
    stall = 1'b0;
    tick(60);
    pulse_clr();
    // 3: integrator never answers the first record -> timeout
    stall = 1'b1;
    push(16'h0101, 16'h0202, 24'h111111, 24'h222222);
    push(16'h0303, 16'h0404, 24'h333333, 24'h444444);
    tick(70);
    chk("t3_timeout", 80'(err_timeout), 80'h1);
    stall = 1'b0;
    tick(20);
    pulse_clr();
    chk("t3_cleared", 80'(err_timeout), 80'h0);
    // 4: done in the chg_start cycle, then a stray done in IDLE
    fix_delay = 0;
    push(16'h0505, 16'h0606, 24'h555555, 24'h666666);
    tick(5);
    idle_kick = 1'b1;
    tick(5);
    // 5: reset while waiting with 3 entries queued
    stall = 1'b1;
    for (int i = 0; i < 4; i++) push(16'(100 + i), 16'(200 + i), 24'($urandom), 24'($urandom));
    tick(3);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    stall = 1'b0;
    chk("t5_empty", 80'(empty), 80'h1);
    idle_kick = 1'b1;
    tick(5);
    // 6: randomized traffic with random integrator latency (wraps pointers,
    //    exercises simultaneous push/pop and overflow)
    rand_delay = 1'b1;
    for (int i = 0; i < 400; i++) begin
      wr_en = ($urandom_range(0, 2) == 0);
      wr_row = 16'($urandom); wr_col = 16'($urandom);
      wr_real = 24'($urandom); wr_img = 24'($urandom);
      clr_err = ($urandom_range(0, 24) == 0);
      tick(1);
    end
    wr_en = 1'b0; clr_err = 1'b0;
    tick(120);
    chk("drain_issue_q", 80'(exp_issue.size()), 80'h0);
    chk("drain_result_q", 80'(exp_res.size()), 80'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
